// File: rtl/uop_sequencer_if.sv
// uop_sequencer_if: bundles the control, ROM and debug signals of the uop_sequencer.
//   slave  : the sequencer. It takes RUN/STEP/HALT_REQ, ROM RESET_uOP/READ_FLAGS and ALU flags.
//            It drives uOP, ZERO_FLAG/COUT_FLAG, HALTED/FAULT, INSTR_DONE and INSTR_COUNT.
//   master : the environment side (front panel, ROM, ALU).
interface uop_sequencer_if #(
    parameter int unsigned ICNT_W = 16
);
    logic              RUN;
    logic              STEP;
    logic              HALT_REQ;
    logic              RESET_uOP;
    logic              READ_FLAGS;
    logic              ALU_ZERO;
    logic              ALU_COUT;
    logic [2:0]        uOP;
    logic              ZERO_FLAG;
    logic              COUT_FLAG;
    logic              HALTED;
    logic              FAULT;
    logic              INSTR_DONE;
    logic [ICNT_W-1:0] INSTR_COUNT;

    modport master (
        output RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        input  uOP, ZERO_FLAG, COUT_FLAG, HALTED, FAULT, INSTR_DONE, INSTR_COUNT
    );

    modport slave (
        input  RUN, STEP, HALT_REQ, RESET_uOP, READ_FLAGS, ALU_ZERO, ALU_COUT,
        output uOP, ZERO_FLAG, COUT_FLAG, HALTED, FAULT, INSTR_DONE, INSTR_COUNT
    );
endinterface

// File: rtl/uop_sequencer.sv
// uop_sequencer: generates the 3-bit microoperation index for the microcode ROM.
// It holds the ZERO/COUT flag register and provides run/halt/single-step control.
// It also keeps a retired-instruction counter and stops in FAULT on runaway microcode.
// Ports:
//   CLK : system clock, rising edge
//   RST : synchronous active-high reset
//   bus : uop_sequencer_if.slave (control inputs, ROM/ALU inputs, registered outputs)
module uop_sequencer #(
    parameter int unsigned MAX_UOP = 6,
    parameter int unsigned ICNT_W  = 16
) (
    input logic            CLK,
    input logic            RST,
    uop_sequencer_if.slave bus
);
    localparam logic [2:0] MaxUop  = 3'(MAX_UOP);
    localparam logic [2:0] UopIdle = 3'd7;

    typedef enum logic [1:0] {StHalted, StRun, StStep, StFault} state_e;

    state_e            state_q;
    logic [2:0]        uop_q;
    logic              zero_q;
    logic              cout_q;
    logic              halted_q;
    logic              fault_q;
    logic              done_q;
    logic              pending_q;
    logic [ICNT_W-1:0] count_q;

    logic active;
    logic qual;
    logic eoi;
    logic wdog;
    logic stop;

    always_comb begin
        active = (state_q == StRun) || (state_q == StStep);
        // The ROM leaves RESET_uOP/READ_FLAGS stale during fetch (0), decode (1) and idle (7).
        qual   = active && (uop_q != 3'd0) && (uop_q != 3'd1) && (uop_q != UopIdle);
        eoi    = qual && bus.RESET_uOP;
        wdog   = active && (uop_q == MaxUop) && !bus.RESET_uOP;
        // A HALT_REQ arriving on the boundary cycle itself also stops there.
        stop   = (state_q == StStep) || !bus.RUN || pending_q || bus.HALT_REQ;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StHalted;
            uop_q     <= UopIdle;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            halted_q  <= 1'b1;
            fault_q   <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            done_q <= eoi;
            if (eoi) begin
                count_q <= count_q + ICNT_W'(1);
            end
            if (qual && bus.READ_FLAGS) begin
                zero_q <= bus.ALU_ZERO;
                cout_q <= bus.ALU_COUT;
            end

            unique case (state_q)
                StHalted: begin
                    pending_q <= pending_q | bus.HALT_REQ;
                    if (bus.RUN) begin
                        state_q  <= StRun;
                        uop_q    <= 3'd0;
                        halted_q <= 1'b0;
                    end else if (bus.STEP) begin
                        state_q  <= StStep;
                        uop_q    <= 3'd0;
                        halted_q <= 1'b0;
                    end
                end
                StRun, StStep: begin
                    if (eoi && stop) begin
                        state_q   <= StHalted;
                        uop_q     <= UopIdle;
                        halted_q  <= 1'b1;
                        pending_q <= 1'b0;
                    end else if (eoi) begin
                        uop_q     <= 3'd0;
                        pending_q <= pending_q | bus.HALT_REQ;
                    end else if (wdog) begin
                        state_q   <= StFault;
                        uop_q     <= UopIdle;
                        fault_q   <= 1'b1;
                        pending_q <= pending_q | bus.HALT_REQ;
                    end else begin
                        uop_q     <= uop_q + 3'd1;
                        pending_q <= pending_q | bus.HALT_REQ;
                    end
                end
                StFault: begin
                    // Only RST leaves FAULT; everything holds.
                end
                default: begin
                    state_q <= StHalted;
                end
            endcase
        end
    end

    assign bus.uOP         = uop_q;
    assign bus.ZERO_FLAG   = zero_q;
    assign bus.COUT_FLAG   = cout_q;
    assign bus.HALTED      = halted_q;
    assign bus.FAULT       = fault_q;
    assign bus.INSTR_DONE  = done_q;
    assign bus.INSTR_COUNT = count_q;
endmodule
